// File: rtl/fft_bit_reverse_buffer.sv
// Single-frame reorder buffer ahead of the first radix-2 DIT butterfly stage.
// A frame is captured in natural order, then replayed in bit-reversed index order.
// Loading and draining never overlap; upstream is stalled while a frame drains.
module fft_bit_reverse_buffer #(
    parameter int unsigned n         = 32,
    parameter int unsigned N_SAMPLES = 8
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         recv_val_i,
    output logic         recv_rdy_o,
    input  logic [n-1:0] recv_r_i,
    input  logic [n-1:0] recv_c_i,
    output logic         send_val_o,
    input  logic         send_rdy_i,
    output logic [n-1:0] send_r_o,
    output logic [n-1:0] send_c_o,
    output logic         send_last_o
);

    localparam int unsigned     LogN    = $clog2(N_SAMPLES);
    localparam logic [LogN-1:0] LastIdx = LogN'(N_SAMPLES - 1);

    typedef enum logic {
        StLoad,
        StDrain
    } state_e;

    state_e            state_q, state_d;
    logic [LogN-1:0]   wr_ptr_q, wr_ptr_d;
    logic [LogN-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LogN-1:0]   rd_addr;
    logic              wr_en;
    logic [2*n-1:0]    rd_word;

    // Sample storage; deliberately not reset, contents are meaningless until written.
    logic [2*n-1:0]    mem_q [N_SAMPLES];

    // Mirror the read pointer bits to get the bit-reversed read address.
    always_comb begin
        rd_addr = '0;
        for (int unsigned i = 0; i < LogN; i++) begin
            rd_addr[i] = rd_ptr_q[LogN-1-i];
        end
    end

    assign rd_word = mem_q[rd_addr];

    // Next-state, pointer updates and outputs; outputs depend only on state and pointers.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        wr_en       = 1'b0;
        recv_rdy_o  = 1'b0;
        send_val_o  = 1'b0;
        send_r_o    = '0;
        send_c_o    = '0;
        send_last_o = 1'b0;

        unique case (state_q)
            StLoad: begin
                recv_rdy_o = 1'b1;
                if (recv_val_i) begin
                    wr_en    = 1'b1;
                    // Pointer wraps naturally since N_SAMPLES is a power of two.
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    if (wr_ptr_q == LastIdx) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                send_val_o  = 1'b1;
                send_r_o    = rd_word[2*n-1:n];
                send_c_o    = rd_word[n-1:0];
                send_last_o = (rd_ptr_q == LastIdx);
                if (send_rdy_i) begin
                    rd_ptr_d = rd_ptr_q + 1'b1;
                    if (rd_ptr_q == LastIdx) begin
                        state_d = StLoad;
                    end
                end
            end
            default: begin
                state_d = StLoad;
            end
        endcase
    end

    // State and pointer registers with asynchronous active-high reset.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= StLoad;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Capture accepted samples at the natural-order write pointer.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= {recv_r_i, recv_c_i};
        end
    end

endmodule
